// File: rtl/ttest_arith_pkg.sv
// Shared constants and types for the ttest arithmetic cores.
// The sequential divider recovers a 32-bit scale factor from the 56-bit
// product made by the 32x24 multiplier. That is why the widths below
// mirror the multiplier's operand and result widths.
//
// Contents:
//   DIV_DVD_W   dividend width (56)
//   DIV_DVS_W   divisor / remainder width (24)
//   DIV_Q_W     quotient width, also the iteration count (32)
//   DIV_CNT_W   iteration counter width (5)
//   DIV_P_W     partial remainder width (one guard bit over the divisor)
//   div_state_t divider control states
package ttest_arith_pkg;

    localparam int DIV_DVD_W = 56;
    localparam int DIV_DVS_W = 24;
    localparam int DIV_Q_W   = 32;
    localparam int DIV_CNT_W = 5;
    localparam int DIV_P_W   = DIV_DVS_W + 1;

    // Counter value of the final restoring iteration.
    localparam logic [DIV_CNT_W-1:0] DIV_LAST_ITER = DIV_CNT_W'(DIV_Q_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } div_state_t;

endpackage

// File: rtl/ttest_udiv_step.sv
// One radix-2 restoring division iteration, purely combinational.
// It shifts the next dividend bit (the MSB of q_i) into the partial
// remainder and trial-subtracts the divisor. If the subtraction does not
// borrow, the difference becomes the new remainder and a 1 enters the
// quotient. If it borrows, the shifted remainder is kept and a 0 enters.
//
// Ports:
//   p_i  partial remainder in (MSB is always 0 between iterations)
//   q_i  dividend/quotient shift register in
//   d_i  divisor
//   p_o  partial remainder out
//   q_o  shift register out, with the new quotient bit in bit 0
module ttest_udiv_step
    import ttest_arith_pkg::*;
(
    input  logic [DIV_P_W-1:0]   p_i,
    input  logic [DIV_Q_W-1:0]   q_i,
    input  logic [DIV_DVS_W-1:0] d_i,
    output logic [DIV_P_W-1:0]   p_o,
    output logic [DIV_Q_W-1:0]   q_o
);

    logic [DIV_P_W-1:0] shifted;
    logic [DIV_P_W:0]   trial;
    logic               unused_p_msb;

    // The remainder entering an iteration is always below the divisor.
    // Its guard bit is therefore never set and drops out of the shift.
    assign unused_p_msb = p_i[DIV_P_W-1];

    // The trial difference is one bit wider than the shifted remainder.
    // Its top bit then acts as the borrow/sign flag.
    always_comb begin
        shifted = {p_i[DIV_DVS_W-1:0], q_i[DIV_Q_W-1]};
        trial   = {1'b0, shifted} - {2'b00, d_i};
        if (!trial[DIV_P_W]) begin
            p_o = trial[DIV_P_W-1:0];
            q_o = {q_i[DIV_Q_W-2:0], 1'b1};
        end else begin
            p_o = shifted;
            q_o = {q_i[DIV_Q_W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/ttest_udiv_56ns_24ns_32_seq.sv
// Sequential unsigned divider: 56-bit dividend / 24-bit divisor gives a
// 32-bit quotient and a 24-bit remainder, one quotient bit per ce cycle.
// Operands whose quotient cannot fit in 32 bits are rejected at accept
// time. So are zero divisors. Both finish immediately with a saturated
// quotient.
//
// Ports:
//   clk          clock, rising edge
//   reset        synchronous active-high reset; overrides ce and start
//   ce           clock enable; freezes every register when low
//   start        request, only honoured in IDLE
//   din0, din1   dividend and divisor, captured on accept
//   busy         high while an operation is in flight or completing
//   done         one ce-cycle pulse marking valid results
//   dout, rem    quotient and remainder, held until the next accept
//   div_by_zero  divisor was zero
//   overflow     quotient would exceed 32 bits
module ttest_udiv_56ns_24ns_32_seq
    import ttest_arith_pkg::*;
#(
    parameter int ID         = 1,
    parameter int din0_WIDTH = DIV_DVD_W,
    parameter int din1_WIDTH = DIV_DVS_W,
    parameter int dout_WIDTH = DIV_Q_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  start,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  busy,
    output logic                  done,
    output logic [dout_WIDTH-1:0] dout,
    output logic [din1_WIDTH-1:0] rem,
    output logic                  div_by_zero,
    output logic                  overflow
);

    div_state_t             state_q, state_d;
    logic [DIV_P_W-1:0]     p_q, p_d;
    logic [DIV_Q_W-1:0]     q_q, q_d;
    logic [DIV_DVS_W-1:0]   dvs_q, dvs_d;
    logic [DIV_CNT_W-1:0]   cnt_q, cnt_d;
    logic [DIV_Q_W-1:0]     dout_q, dout_d;
    logic [DIV_DVS_W-1:0]   rem_q, rem_d;
    logic                   dbz_q, dbz_d;
    logic                   ovf_q, ovf_d;

    logic [DIV_P_W-1:0]     step_p;
    logic [DIV_Q_W-1:0]     step_q;
    logic                   unused_id;

    // The instance tag has no functional effect.
    assign unused_id = ID[0];

    ttest_udiv_step u_step (
        .p_i (p_q),
        .q_i (q_q),
        .d_i (dvs_q),
        .p_o (step_p),
        .q_o (step_q)
    );

    // Register bank. Reset returns to IDLE with cleared results. This
    // aborts any operation in flight without a done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            p_q     <= '0;
            q_q     <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            q_q     <= q_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
        end
    end

    // Control and datapath next-state. Everything holds unless ce is
    // high. A dividend whose top 24 bits already reach the divisor would
    // need more than 32 quotient bits. It is therefore flagged at accept
    // instead of being iterated.
    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        q_d     = q_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;

        if (ce) begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        dbz_d = 1'b0;
                        ovf_d = 1'b0;
                        if (din1 == '0) begin
                            dbz_d   = 1'b1;
                            dout_d  = '1;
                            rem_d   = '0;
                            state_d = DONE;
                        end else if (din0[DIV_DVD_W-1:DIV_Q_W] >= din1) begin
                            ovf_d   = 1'b1;
                            dout_d  = '1;
                            rem_d   = '0;
                            state_d = DONE;
                        end else begin
                            p_d     = {1'b0, din0[DIV_DVD_W-1:DIV_Q_W]};
                            q_d     = din0[DIV_Q_W-1:0];
                            dvs_d   = din1;
                            cnt_d   = '0;
                            state_d = CALC;
                        end
                    end
                end
                CALC: begin
                    p_d   = step_p;
                    q_d   = step_q;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == DIV_LAST_ITER) begin
                        dout_d  = step_q;
                        rem_d   = step_p[DIV_DVS_W-1:0];
                        state_d = DONE;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign dout        = dout_q;
    assign rem         = rem_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_ttest_udiv_56ns_24ns_32_seq.sv
// Self-checking bench for the sequential 56/24 unsigned divider.
// Directed vectors come from a table. Random operands are checked
// against a plain-arithmetic reference. Hand-written sequences cover
// reset during an operation, and a start raised while done is high.
module tb_ttest_udiv_56ns_24ns_32_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce;
    logic        start;
    logic [55:0] din0;
    logic [23:0] din1;
    logic        busy;
    logic        done;
    logic [31:0] dout;
    logic [23:0] rem;
    logic        div_by_zero;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [55:0] a;
        logic [23:0] b;
        logic [31:0] q;
        logic [23:0] r;
        bit          dbz;
        bit          ovf;
        bit          ceToggle;
        int          pulseAt;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    ttest_udiv_56ns_24ns_32_seq #(.ID(1)) dut (
        .clk         (clk),
        .reset       (reset),
        .ce          (ce),
        .start       (start),
        .din0        (din0),
        .din1        (din1),
        .busy        (busy),
        .done        (done),
        .dout        (dout),
        .rem         (rem),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    // Compare one observed value against its expectation and tally it.
    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic [55:0] a, input logic [23:0] b,
                                input logic [31:0] q, input logic [23:0] r,
                                input bit dbz, input bit ovf,
                                input bit tog, input int pulse);
        vec_t v;
        v.a = a; v.b = b; v.q = q; v.r = r;
        v.dbz = dbz; v.ovf = ovf; v.ceToggle = tog; v.pulseAt = pulse;
        return v;
    endfunction

    // Reference: ordinary integer division, saturating on a zero divisor
    // or on a quotient that needs more than 32 bits.
    function automatic vec_t refModel(input logic [55:0] a, input logic [23:0] b);
        vec_t v;
        longint unsigned quo;
        v = mk(a, b, 32'hFFFFFFFF, 24'd0, 1'b0, 1'b0, 1'b0, -1);
        if (b == 24'd0) begin
            v.dbz = 1'b1;
        end else begin
            quo = 64'(a) / 64'(b);
            if (quo > 64'h0000_0000_FFFF_FFFF) begin
                v.ovf = 1'b1;
            end else begin
                v.q = 32'(quo);
                v.r = 24'(64'(a) % 64'(b));
            end
        end
        return v;
    endfunction

    // Issue one request and run until done is seen or a cycle budget
    // expires. It counts the ce-high edges after accept and any cycle in
    // which busy dropped too early. It also optionally pulses start
    // mid-operation.
    task automatic applyStimulus(input vec_t v, output int ceEdges, output int busyDrops,
                                 output bit sawTimeout);
        din0 = v.a; din1 = v.b; start = 1'b1; ce = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        din0 = {24'($urandom), 32'($urandom)};
        din1 = 24'($urandom);
        ceEdges = 0; busyDrops = 0; sawTimeout = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (done) break;
            if (!busy) busyDrops++;
            ce = v.ceToggle ? (cyc % 2 == 1) : 1'b1;
            start = (v.pulseAt >= 0 && cyc >= v.pulseAt && cyc < v.pulseAt + 2);
            @(posedge clk);
            if (ce) ceEdges++;
            @(negedge clk);
        end
        start = 1'b0;
        if (!done) sawTimeout = 1'b1;
    endtask

    // Full transaction: results, latency and busy while done is high.
    // A start raised during the done cycle must be ignored. Results must
    // hold afterwards.
    task automatic runOp(input vec_t v);
        int  ceEdges, busyDrops;
        bit  sawTimeout;
        applyStimulus(v, ceEdges, busyDrops, sawTimeout);
        checkOutput("timeout", 64'(sawTimeout), 64'd0);
        checkOutput("dout", 64'(dout), 64'(v.q));
        checkOutput("rem", 64'(rem), 64'(v.r));
        checkOutput("div_by_zero", 64'(div_by_zero), 64'(v.dbz));
        checkOutput("overflow", 64'(overflow), 64'(v.ovf));
        checkOutput("latency ce edges", 64'(ceEdges), (v.dbz || v.ovf) ? 64'd0 : 64'd32);
        checkOutput("busy gaps", 64'(busyDrops), 64'd0);
        checkOutput("busy with done", 64'(busy), 64'd1);
        ce = 1'b1; start = 1'b1; din0 = 56'd77; din1 = 24'd0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        checkOutput("done single pulse", 64'(done), 64'd0);
        checkOutput("start during done ignored", 64'(busy), 64'd0);
        checkOutput("dout hold", 64'(dout), 64'(v.q));
        checkOutput("rem hold", 64'(rem), 64'(v.r));
        checkOutput("flags hold", {62'd0, div_by_zero, overflow}, {62'd0, v.dbz, v.ovf});
    endtask

    initial begin
        logic [55:0] ra;
        logic [31:0] ra32;
        logic [23:0] rb;
        bit          sawDone;

        reset = 1'b1; ce = 1'b0; start = 1'b0; din0 = '0; din1 = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        $display("[TB] reset state");
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset done", 64'(done), 64'd0);
        checkOutput("reset dout", 64'(dout), 64'd0);
        checkOutput("reset rem", 64'(rem), 64'd0);
        checkOutput("reset flags", {62'd0, div_by_zero, overflow}, 64'd0);

        vecs.push_back(mk(56'hFFFFFEFF000001, 24'hFFFFFF, 32'hFFFFFFFF, 24'd0, 0, 0, 0, -1));
        vecs.push_back(mk(56'd100, 24'd7, 32'd14, 24'd2, 0, 0, 0, -1));
        vecs.push_back(mk(56'd12345, 24'd0, 32'hFFFFFFFF, 24'd0, 1, 0, 0, -1));
        vecs.push_back(mk(56'h00000100000000, 24'd1, 32'hFFFFFFFF, 24'd0, 0, 1, 0, -1));
        vecs.push_back(mk(56'h000000FFFFFFFF, 24'd1, 32'hFFFFFFFF, 24'd0, 0, 0, 0, -1));
        vecs.push_back(mk(56'd1000, 24'd3, 32'd333, 24'd1, 0, 0, 1, 20));

        $display("[TB] directed vectors");
        for (int i = 0; i < vecs.size(); i++) begin
            runOp(vecs[i]);
        end

        // Reset after ten iterations: no done, cleared outputs, and the
        // next request runs normally.
        $display("[TB] reset during calculation");
        din0 = 56'd1000; din1 = 24'd3; start = 1'b1; ce = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        sawDone = 1'b0;
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
            if (done) sawDone = 1'b1;
        end
        checkOutput("busy before abort", 64'(busy), 64'd1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checkOutput("no done before abort", 64'(sawDone), 64'd0);
        checkOutput("abort done", 64'(done), 64'd0);
        checkOutput("abort busy", 64'(busy), 64'd0);
        checkOutput("abort dout", 64'(dout), 64'd0);
        checkOutput("abort rem", 64'(rem), 64'd0);
        checkOutput("abort flags", {62'd0, div_by_zero, overflow}, 64'd0);
        runOp(mk(56'd50, 24'd5, 32'd10, 24'd0, 0, 0, 0, -1));

        $display("[TB] random operands");
        for (int i = 0; i < 24; i++) begin
            case (i % 4)
                0: begin
                    rb = 24'($urandom_range(1, 255));
                    ra = {16'd0, 8'($urandom), 32'($urandom)};
                end
                1: begin
                    rb = 24'($urandom_range(1, 24'hFFFFFF));
                    ra = {24'($urandom), 32'($urandom)};
                end
                2: begin
                    rb = 24'($urandom_range(1, 24'hFFFFFF));
                    ra32 = $urandom;
                    ra = 56'(64'(ra32) * 64'(rb));
                end
                default: begin
                    rb = (i == 3) ? 24'd0 : 24'($urandom);
                    ra = {24'($urandom_range(0, 4)), 32'($urandom)};
                end
            endcase
            runOp(refModel(ra, rb));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
